hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter MAX_STALL, default 255: stall-cycle count at which stall_timeout sets.
REQ-002 Parameter CNT_W, default 32: width of perf_stall_total.
REQ-003 clk  in  1  sole clock; all state updates on negedge clk, matching the pipeline registers it drives.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 icache_hit  in  1  instruction fetch hit this cycle.
REQ-006 dcache_hit  in  1  data access hit this cycle; ignored when mem_access=0.
REQ-007 mem_access  in  1  MEM stage MemRead|MemWrite.
REQ-008 ex_MemRead  in  1  load in EX.
REQ-009 ex_rt  in  5  EX destination of load.
REQ-010 id_rs, id_rt  in  5 each  ID source registers.
REQ-011 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-012 ex_branch_taken  in  1  EX resolved taken branch.
REQ-013 pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  pipeline register load enables (drive "hit" of each stage).
REQ-014 if_id_flush, id_ex_flush  out  1 each  load a bubble (all control fields 0) into that register.
REQ-015 state  out  2  RUN=0, DSTALL=1, ISTALL=2.
REQ-016 stall_timeout  out  1  sticky watchdog flag.
REQ-017 perf_stall_total  out  CNT_W  total stalled cycles, saturating.

Function
REQ-018 dmiss = mem_access & ~dcache_hit; imiss = ~icache_hit; lduse = ex_MemRead & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-019 Enables/flushes SHALL be combinational from current inputs (zero-cycle latency), priority dmiss > ex_branch_taken > lduse > imiss > none.
REQ-020 dmiss: all four enables 0, both flushes 0 (full freeze).
REQ-021 ex_branch_taken (no dmiss): all enables 1, if_id_flush=1, id_ex_flush=1; lduse and imiss ignored that cycle.
REQ-022 lduse: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1; imiss that cycle ignored.
REQ-023 imiss only: pc_en=0, if_id_en=1 with if_id_flush=1, id_ex_en=1, ex_mem_en=1.
REQ-024 None active: all enables 1, flushes 0.
REQ-025 FSM, each negedge: RUN->DSTALL on dmiss; RUN->ISTALL on imiss & ~dmiss & ~ex_branch_taken & ~lduse; DSTALL->ISTALL when ~dmiss & imiss; DSTALL->RUN when ~dmiss & ~imiss; ISTALL->DSTALL on dmiss; ISTALL->RUN on ~imiss & ~dmiss; otherwise hold.
REQ-026 stall_cnt (internal, 16 bits) SHALL increment each negedge in DSTALL or ISTALL, saturate at 0xFFFF, clear to 0 on entry to RUN; DSTALL<->ISTALL transfers do not clear it.
REQ-027 stall_timeout SHALL set on the edge stall_cnt becomes MAX_STALL and remain 1 until reset.
REQ-028 perf_stall_total SHALL increment on every negedge where any of pc_en/if_id_en/id_ex_en/ex_mem_en is 0, saturating at all-ones.
REQ-029 Outputs SHALL be X-free for all input combinations, including simultaneous dmiss, branch and lduse.

Reset
REQ-030 rst_n=0 SHALL immediately force state=RUN, stall_cnt=0, stall_timeout=0, perf_stall_total=0, regardless of clk; combinational outputs follow inputs.
REQ-031 Reset asserted mid-stall SHALL abandon the stall; first edge after release evaluates from RUN.

Structure
REQ-032 State encodings (RUN/DSTALL/ISTALL) and bubble definition SHALL live in the shared pipeline package.
REQ-033 Priority decode SHALL be one always_comb block; FSM, counters and watchdog in one sequential block; no sub-modules.

Verification
REQ-034 ex_MemRead=1, ex_rt=5, id_rs=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; ex_rt=0 same stimulus -> no stall.
REQ-035 mem_access=1, dcache_hit=0 for 3 cycles -> all enables 0, state=DSTALL for 3 edges, perf_stall_total=3, then RUN.
REQ-036 ex_branch_taken=1 with lduse and imiss -> if_id_flush=1, id_ex_flush=1, pc_en=1, state stays RUN.
REQ-037 MAX_STALL=4, icache_hit=0 held 6 cycles -> stall_timeout rises on 4th edge, stays 1 after icache_hit=1.
REQ-038 dmiss and imiss together, dmiss clears first -> DSTALL->ISTALL->RUN, stall_cnt not cleared at transfer.
REQ-039 rst_n pulsed low between edges during DSTALL -> state=RUN, counters 0 immediately.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall FSM encodings and pipeline-register control words.
`default_nettype none

package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    ISTALL = 2'd2
  } stall_state_t;

  // A flush loads a bubble: every control field of the target register goes to 0.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE   = pipe_ctrl_t'(6'b1111_00);
  localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(6'b0000_00);
  localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(6'b1111_11);
  localparam pipe_ctrl_t CTRL_LDUSE  = pipe_ctrl_t'(6'b0011_01);
  localparam pipe_ctrl_t CTRL_IMISS  = pipe_ctrl_t'(6'b0111_10);

  function automatic logic any_hold(input pipe_ctrl_t c);
    return ~(c.pc_en & c.if_id_en & c.id_ex_en & c.ex_mem_en);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: priority enable/flush decode, stall FSM,
// stall watchdog and saturating stalled-cycle counter (all state on negedge clk).
`default_nettype none

module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = 255,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_hit,
  input  logic             dcache_hit,
  input  logic             mem_access,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] perf_stall_total
);

  stall_state_t cur_state;
  stall_state_t nxt_state;
  pipe_ctrl_t   ctrl;
  logic [15:0]  stall_cnt;
  logic [15:0]  cnt_nxt;
  logic         dmiss;
  logic         imiss;
  logic         lduse;

  always_comb begin
    dmiss     = mem_access & ~dcache_hit;
    imiss     = ~icache_hit;
    lduse     = ex_MemRead & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    ctrl      = CTRL_NONE;
    nxt_state = cur_state;
    cnt_nxt   = stall_cnt;

    if (dmiss)                ctrl = CTRL_FREEZE;
    else if (ex_branch_taken) ctrl = CTRL_BRANCH;
    else if (lduse)           ctrl = CTRL_LDUSE;
    else if (imiss)           ctrl = CTRL_IMISS;

    case (cur_state)
      RUN: begin
        if (dmiss)                                    nxt_state = DSTALL;
        else if (imiss & ~ex_branch_taken & ~lduse)   nxt_state = ISTALL;
      end
      DSTALL: begin
        if (!dmiss) nxt_state = imiss ? ISTALL : RUN;
      end
      ISTALL: begin
        if (dmiss)       nxt_state = DSTALL;
        else if (!imiss) nxt_state = RUN;
      end
      default: nxt_state = RUN;
    endcase

    // The count covers every edge that lands in a stall state; DSTALL<->ISTALL keeps it.
    if (nxt_state == RUN)        cnt_nxt = 16'd0;
    else if (stall_cnt != 16'hFFFF) cnt_nxt = stall_cnt + 16'd1;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state        <= RUN;
      stall_cnt        <= 16'd0;
      stall_timeout    <= 1'b0;
      perf_stall_total <= '0;
    end else begin
      cur_state <= nxt_state;
      stall_cnt <= cnt_nxt;
      if ((nxt_state != RUN) && (32'(cnt_nxt) == MAX_STALL))
        stall_timeout <= 1'b1;
      if (any_hold(ctrl) && (perf_stall_total != {CNT_W{1'b1}}))
        perf_stall_total <= perf_stall_total + 1'b1;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign state       = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: reference model plus directed scenarios.
`default_nettype none

module tb_hazard_stall_ctrl;

  localparam int unsigned MAX_STALL = 4;
  localparam int          CNT_W     = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             icache_hit = 1'b1;
  logic             dcache_hit = 1'b1;
  logic             mem_access = 1'b0;
  logic             ex_MemRead = 1'b0;
  logic [4:0]       ex_rt = 5'd0;
  logic [4:0]       id_rs = 5'd0;
  logic [4:0]       id_rt = 5'd0;
  logic             id_uses_rt = 1'b0;
  logic             ex_branch_taken = 1'b0;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
  logic [1:0]       state;
  logic             stall_timeout;
  logic [CNT_W-1:0] perf_stall_total;

  int tests = 0;
  int fails = 0;

  // Reference model state (plain integers, updated on the active edge)
  int m_state = 0;
  int m_cnt   = 0;
  int m_to    = 0;
  int m_perf  = 0;

  hazard_stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .icache_hit(icache_hit), .dcache_hit(dcache_hit),
    .mem_access(mem_access), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state),
    .stall_timeout(stall_timeout), .perf_stall_total(perf_stall_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_dmiss();
    return mem_access && !dcache_hit;
  endfunction
  function automatic bit f_imiss();
    return !icache_hit;
  endfunction
  function automatic bit f_lduse();
    return ex_MemRead && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
  function automatic logic [5:0] exp_ctrl();
    if (f_dmiss())       return 6'b0000_00;
    if (ex_branch_taken) return 6'b1111_11;
    if (f_lduse())       return 6'b0011_01;
    if (f_imiss())       return 6'b0111_10;
    return 6'b1111_00;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_to = 0; m_perf = 0;
    end else begin
      int nxt;
      logic [5:0] c;
      c = exp_ctrl();
      if (c[5:2] != 4'hF && m_perf < 255) m_perf++;
      if (f_dmiss())      nxt = 1;
      else if (m_state == 0) nxt = (f_imiss() && !ex_branch_taken && !f_lduse()) ? 2 : 0;
      else                nxt = f_imiss() ? 2 : 0;
      if (nxt == 0) m_cnt = 0;
      else if (m_cnt < 65535) m_cnt++;
      if (nxt != 0 && m_cnt == MAX_STALL) m_to = 1;
      m_state = nxt;
    end
  end

  always @(posedge clk) begin
    #2;
    check("ctrl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}),
          32'(exp_ctrl()));
    check("state", 32'(state), 32'(m_state));
    check("timeout", 32'(stall_timeout), 32'(m_to));
    check("perf", 32'(perf_stall_total), 32'(m_perf));
  end

  task automatic idle();
    icache_hit = 1'b1; dcache_hit = 1'b1; mem_access = 1'b0; ex_MemRead = 1'b0;
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_branch_taken = 1'b0;
  endtask

  // Advance n active edges; returns 1 time unit after the following posedge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    cyc(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_perf", 32'(perf_stall_total), 32'd0);
    check("rst_timeout", 32'(stall_timeout), 32'd0);
    check("rst_comb_pc_en", 32'(pc_en), 32'd1);
    rst_n = 1'b1;
    cyc(1);

    // Load-use hazard, then same stimulus with ex_rt = 0
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #1;
    check("lduse_ctrl", 32'({pc_en, if_id_en, id_ex_flush}), 32'b001);
    cyc(1);
    check("lduse_state", 32'(state), 32'd0);
    check("lduse_perf", 32'(perf_stall_total), 32'd1);
    ex_rt = 5'd0; id_rs = 5'd0; #1;
    check("lduse_r0_ctrl", 32'({pc_en, if_id_en, id_ex_flush}), 32'b110);
    cyc(1);

    // Branch wins over load-use and imiss
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; icache_hit = 1'b0; ex_branch_taken = 1'b1; #1;
    check("br_ctrl", 32'({pc_en, if_id_flush, id_ex_flush}), 32'b111);
    cyc(1);
    check("br_state", 32'(state), 32'd0);
    idle();
    cyc(1);

    // Three-cycle data miss
    mem_access = 1'b1; dcache_hit = 1'b0; #1;
    check("dmiss_en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en}), 32'd0);
    cyc(3);
    check("dmiss_state", 32'(state), 32'd1);
    check("dmiss_perf", 32'(perf_stall_total), 32'd4);
    idle();
    cyc(1);
    check("dmiss_run", 32'(state), 32'd0);
    check("dmiss_no_to", 32'(stall_timeout), 32'd0);

    // dmiss + imiss, dmiss clears first: counter carries across the transfer
    mem_access = 1'b1; dcache_hit = 1'b0; icache_hit = 1'b0;
    cyc(2);
    check("both_dstall", 32'(state), 32'd1);
    dcache_hit = 1'b1;
    cyc(1);
    check("both_istall", 32'(state), 32'd2);
    check("both_to_early", 32'(stall_timeout), 32'd0);
    cyc(1);
    check("both_to_set", 32'(stall_timeout), 32'd1);
    icache_hit = 1'b1;
    cyc(1);
    check("both_run", 32'(state), 32'd0);
    check("both_perf", 32'(perf_stall_total), 32'd8);

    rst_n = 1'b0; #1;
    check("rst2_to", 32'(stall_timeout), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Watchdog from a held icache miss
    icache_hit = 1'b0;
    cyc(3);
    check("wd_edge3", 32'(stall_timeout), 32'd0);
    cyc(1);
    check("wd_edge4", 32'(stall_timeout), 32'd1);
    cyc(2);
    icache_hit = 1'b1;
    cyc(2);
    check("wd_sticky", 32'(stall_timeout), 32'd1);
    check("wd_run", 32'(state), 32'd0);

    // Simultaneous dmiss, branch and load-use: full freeze
    mem_access = 1'b1; dcache_hit = 1'b0; ex_branch_taken = 1'b1;
    ex_MemRead = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
    check("all_freeze", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}), 32'd0);
    idle();
    mem_access = 1'b1; dcache_hit = 1'b0;

    // Reset pulsed between edges during DSTALL
    cyc(2);
    check("mid_dstall", 32'(state), 32'd1);
    rst_n = 1'b0; #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_perf", 32'(perf_stall_total), 32'd0);
    check("mid_rst_to", 32'(stall_timeout), 32'd0);
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_state", 32'(state), 32'd1);
    check("post_rst_perf", 32'(perf_stall_total), 32'd1);

    // Saturation of the stalled-cycle counter
    cyc(300);
    check("perf_sat", 32'(perf_stall_total), 32'd255);
    idle();
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
